// File: rtl/l1_writeback_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : l1_writeback_engine_if
// Desc     : Bundles the cache-controller request, data-array read port and
//            memory write channel of the L1 writeback engine. The master
//            modport is the engine side, the slave modport its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface l1_writeback_engine_if #(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_BYTES = 16
);
  localparam int WORDS         = LINE_BYTES / 4;
  localparam int INDEX_BITS    = $clog2(NUM_SETS);
  localparam int WAY_BITS      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WORD_SEL_BITS = (LINE_BYTES > 4) ? $clog2(WORDS) : 1;
  localparam int OFFSET_BITS   = $clog2(LINE_BYTES);
  localparam int TAG_BITS      = 32 - INDEX_BITS - OFFSET_BITS;

  // Controller request
  logic                     wb_req_valid;
  logic                     wb_req_ready;
  logic [INDEX_BITS-1:0]    wb_req_index;
  logic [WAY_BITS-1:0]      wb_req_way;
  logic [TAG_BITS-1:0]      wb_req_tag;
  // Data array read port
  logic [INDEX_BITS-1:0]    da_index;
  logic [WAY_BITS-1:0]      da_way;
  logic [WORD_SEL_BITS-1:0] da_word_sel;
  logic [31:0]              da_rdata;
  // Memory write channel
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [31:0]              mem_req_addr;
  logic                     mem_wvalid;
  logic                     mem_wready;
  logic [31:0]              mem_wdata;
  logic                     mem_wlast;
  logic                     mem_ack;
  // Status
  logic                     wb_done;
  logic                     wb_error;
  logic                     busy;

  modport master (
    input  wb_req_valid, wb_req_index, wb_req_way, wb_req_tag,
    input  da_rdata, mem_req_ready, mem_wready, mem_ack,
    output wb_req_ready, da_index, da_way, da_word_sel,
    output mem_req_valid, mem_req_addr, mem_wvalid, mem_wdata, mem_wlast,
    output wb_done, wb_error, busy
  );

  modport slave (
    output wb_req_valid, wb_req_index, wb_req_way, wb_req_tag,
    output da_rdata, mem_req_ready, mem_wready, mem_ack,
    input  wb_req_ready, da_index, da_way, da_word_sel,
    input  mem_req_valid, mem_req_addr, mem_wvalid, mem_wdata, mem_wlast,
    input  wb_done, wb_error, busy
  );
endinterface
`default_nettype wire

// File: rtl/l1_writeback_engine.sv
`default_nettype none
// ============================================================================
// Module   : l1_writeback_engine
// Desc     : Drains one dirty victim line to the next memory level: latches
//            set/way/tag, issues a line-aligned address phase, streams the
//            line word-by-word from the data array, then waits for mem_ack
//            and pulses wb_done.
// Options  : L1_WB_ACK_TIMEOUT_EN - abandon WAIT_ACK after ACK_TIMEOUT cycles
//            and pulse wb_error instead of wb_done.
// Revision : 1.0 - initial release
// ============================================================================
module l1_writeback_engine #(
  parameter int NUM_SETS    = 64,
  parameter int NUM_WAYS    = 4,
  parameter int LINE_BYTES  = 16,
  parameter int ACK_TIMEOUT = 256
) (
  input wire                    clk,
  input wire                    rst_n,
  l1_writeback_engine_if.master bus
);
  localparam int WORDS         = LINE_BYTES / 4;
  localparam int INDEX_BITS    = $clog2(NUM_SETS);
  localparam int WAY_BITS      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WORD_SEL_BITS = (LINE_BYTES > 4) ? $clog2(WORDS) : 1;
  localparam int OFFSET_BITS   = $clog2(LINE_BYTES);
  localparam int TAG_BITS      = 32 - INDEX_BITS - OFFSET_BITS;
  localparam logic [WORD_SEL_BITS-1:0] LAST_WORD = WORD_SEL_BITS'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ADDR     = 2'd1,
    S_DATA     = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [WORD_SEL_BITS-1:0] cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]    idx_q, idx_d;
  logic [WAY_BITS-1:0]      way_q, way_d;
  logic [TAG_BITS-1:0]      tag_q, tag_d;
  logic                     done_q, done_d;
  logic                     last_beat;

  // Reject configurations the word/offset arithmetic cannot represent
  if (ACK_TIMEOUT < 1 || LINE_BYTES < 4 || (LINE_BYTES % 4) != 0) begin : g_param_check
    $error("l1_writeback_engine: unsupported LINE_BYTES/ACK_TIMEOUT");
  end

`ifdef L1_WB_ACK_TIMEOUT_EN
  localparam int TMO_BITS = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(ACK_TIMEOUT - 1);
  logic [TMO_BITS-1:0] timer_q, timer_d;
  logic                error_q, error_d;
`endif

  assign last_beat = (state_q == S_DATA) && (cnt_q == LAST_WORD);

  // Next-state and datapath update for the drain sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    way_d   = way_q;
    tag_d   = tag_q;
    done_d  = 1'b0;
`ifdef L1_WB_ACK_TIMEOUT_EN
    timer_d = timer_q;
    error_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.wb_req_valid) begin
          idx_d   = bus.wb_req_index;
          way_d   = bus.wb_req_way;
          tag_d   = bus.wb_req_tag;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.mem_wready) begin
          // Counter holds on the last beat so it never wraps
          if (last_beat) begin
            state_d = S_WAIT_ACK;
`ifdef L1_WB_ACK_TIMEOUT_EN
            timer_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        // An ack on the expiry cycle wins over the timeout
        if (bus.mem_ack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`ifdef L1_WB_ACK_TIMEOUT_EN
        else if (timer_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously so a mid-burst reset aborts at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      done_q  <= 1'b0;
`ifdef L1_WB_ACK_TIMEOUT_EN
      timer_q <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      tag_q   <= tag_d;
      done_q  <= done_d;
`ifdef L1_WB_ACK_TIMEOUT_EN
      timer_q <= timer_d;
      error_q <= error_d;
`endif
    end
  end

  assign bus.wb_req_ready  = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.mem_req_valid = (state_q == S_ADDR);
  assign bus.mem_wvalid    = (state_q == S_DATA);
  assign bus.mem_wlast     = last_beat;
  assign bus.mem_req_addr  = {tag_q, idx_q, {OFFSET_BITS{1'b0}}};
  assign bus.da_index      = idx_q;
  assign bus.da_way        = way_q;
  assign bus.da_word_sel   = cnt_q;
  assign bus.mem_wdata     = bus.da_rdata;
  assign bus.wb_done       = done_q;
`ifdef L1_WB_ACK_TIMEOUT_EN
  assign bus.wb_error      = error_q;
`else
  assign bus.wb_error      = 1'b0;
`endif

endmodule
`default_nettype wire
